mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single-ported instruction/data memory of the MIPS toplevel between the instruction-fetch requester and the data load/store requester. It grants at most one access per cycle and routes the one-cycle-later read response back to the owner. Data accesses win contention by default; an optional starvation guard bounds instruction-fetch stall.

## Interface
- ADDR_W, 10, word address width (covers both the 10-bit instruction and 8-bit data address spaces; data addresses are zero-extended by the requester)
- DATA_W, 32, memory word width
- STARVE_MAX, 4, consecutive contended data grants before a forced instruction grant (guard build only); legal range 1..15
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  instruction fetch request; held with i_addr stable until granted
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch granted this cycle (combinational)
- i_rvalid  out  1  fetch data valid on i_rdata
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until granted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data access granted this cycle (combinational)
- d_rvalid  out  1  load data valid / store acknowledged
- d_rdata  out  DATA_W  load data; 0 for store acks
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0

## Operation
- Arbitration each cycle: only i_req -> i_gnt; only d_req -> d_gnt; both -> d_gnt, unless starvation guard forces i_gnt. Never both grants.
- Granted request drives mem_en=1, mem_we=d_we (0 for fetch), mem_addr, mem_wdata (0 for fetch) in the same cycle; no grant -> all mem_* outputs 0.
- Owner register (resp_owner: NONE/INST/DATA) loads the granted side each edge, NONE if no grant.
- Responses: i_rvalid = (resp_owner==INST); d_rvalid = (resp_owner==DATA). i_rdata = mem_rdata when INST else 0; d_rdata = mem_rdata when DATA and the access was a load, else 0 (store flag registered alongside owner).
- Back-to-back grants allowed every cycle; response stream is in grant order.

## Timing
- Grant latency 0 cycles (same cycle as request when uncontended); response latency exactly 1 cycle after grant.
- Reset values: i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we = 0; i_rdata, d_rdata, mem_addr, mem_wdata = 0; resp_owner = NONE; starve count = 0.
- rst asserted in the cycle after a grant: in-flight response is dropped, no rvalid in any cycle where rst was high on the preceding edge.
- While rst is high, no grants issue regardless of requests.
- Requester dropping req before grant is legal; nothing issues.

## Configuration
- ARB_STARVE_GUARD_EN defined: 4-bit counter increments on each cycle with d_gnt while i_req=1; clears on any i_gnt or when i_req=0. When count==STARVE_MAX and both request, i_gnt is given instead of d_gnt and count clears.
- Not defined: strict data priority; instruction fetch may stall indefinitely under continuous d_req; no counter logic.

## Structure
- Package mem_arb_pkg: owner enum (OWN_NONE=2'd0, OWN_INST=2'd1, OWN_DATA=2'd2), default ADDR_W/DATA_W constants.
- One sub-module arb_starve_ctr (counter + force flag), instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- Reset: rst=1 for 2 cycles with i_req=d_req=1 -> no grants, all outputs 0; release -> d_gnt in first cycle.
- Fetch only: i_req, i_addr=10'h004, memory word 32'h2008_0005 -> i_gnt same cycle, i_rvalid=1 and i_rdata=32'h2008_0005 next cycle, d_rvalid=0.
- Store then load: d_we=1, d_addr=10'h010, d_wdata=32'hDEAD_BEEF, then load 10'h010 -> store ack d_rvalid=1 d_rdata=0, next cycle d_rdata=32'hDEADBEEF.
- Contention, guard off: i_req and d_req held 10 cycles -> 10 consecutive d_gnt, no i_gnt.
- Contention, ARB_STARVE_GUARD_EN, STARVE_MAX=4 -> pattern d,d,d,d,i repeating; each response routed to correct side.
- Reset mid-flight: grant fetch, assert rst next cycle -> i_rvalid stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
// Also used by the ARB_STARVE_GUARD_EN build of mem_port_arbiter.
package mem_arb_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_INST = 2'd1,
      OWN_DATA = 2'd2
   } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-side signals of the shared memory port arbiter.
// slave = arbiter view; master = requesters plus the memory array.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/arb_starve_ctr.sv
// Counts contended data grants while a fetch waits; raises force_i once the
// fetch has lost STARVE_MAX times in a row. Used only with ARB_STARVE_GUARD_EN.
module arb_starve_ctr #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   input  logic i_gnt,
   input  logic d_gnt,
   output logic force_i
);

   localparam logic [3:0] LIMIT = 4'(STARVE_MAX);

   logic [3:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (!i_req || i_gnt) begin
         count_d = '0;
      end else if (d_gnt) begin
         count_d = count_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Only a registered compare feeds the grant logic, so there is no comb loop.
   assign force_i = (count_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store; data wins ties.
// Define ARB_STARVE_GUARD_EN to bound fetch stall to STARVE_MAX lost cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  logic   force_i;
  logic   i_gnt, d_gnt;
  owner_e resp_owner_q, resp_owner_d;
  logic   store_q, store_d;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk     (clk),
    .rst     (rst),
    .i_req   (bus.i_req),
    .i_gnt   (i_gnt),
    .d_gnt   (d_gnt),
    .force_i (force_i)
  );
`else
  assign force_i = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    i_gnt         = 1'b0;
    d_gnt         = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    resp_owner_d  = OWN_NONE;
    store_d       = 1'b0;

    if (!rst) begin
      if (bus.i_req && (!bus.d_req || force_i)) begin
        i_gnt = 1'b1;
      end else if (bus.d_req) begin
        d_gnt = 1'b1;
      end
    end

    if (d_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
      resp_owner_d  = OWN_DATA;
      store_d       = bus.d_we;
    end else if (i_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.i_addr;
      resp_owner_d  = OWN_INST;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so each flop samples pre-edge values whatever the block order.
    if (rst) begin
      resp_owner_q <= OWN_NONE;
      store_q      <= 1'b0;
    end else begin
      resp_owner_q <= resp_owner_d;
      store_q      <= store_d;
    end
  end

  assign bus.i_gnt = i_gnt;
  assign bus.d_gnt = d_gnt;

  // Gating with rst drops a response whose reset lands in the response cycle.
  assign bus.i_rvalid = !rst && (resp_owner_q == OWN_INST);
  assign bus.d_rvalid = !rst && (resp_owner_q == OWN_DATA);
  assign bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata  = (bus.d_rvalid && !store_q) ? bus.mem_rdata : '0;

endmodule
